// File: rtl/muldiv_seq.sv
// muldiv_seq: sequencer for the shared HI/LO multiply/divide resources.
//
// Accepts MULT, DIV, MTHI and MTLO requests. It launches the external
// iterative multiplier or divider with a one-cycle start pulse, counts that
// unit's fixed latency, and then captures the result into HI/LO. While a run
// is in flight, any new HI/LO request or MFHI/MFLO read stalls the pipeline.
//
// Parameters
//   MULT_LAT  cycles from the start edge to a valid multiplier result (1..63)
//   DIV_LAT   cycles from the start edge to a valid divider result (1..63)
// Ports
//   clk, reset             clock; asynchronous active-high reset
//   op_valid/op_code       request: 00 MULT, 01 DIV, 10 MTHI, 11 MTLO
//   op_a, op_b             rs / rt operands
//   cancel                 pipeline flush: aborts a run, blocks acceptance
//   mf_req                 MFHI/MFLO in decode this cycle
//   unit_a, unit_b         operands forwarded to the datapaths
//   mult_start, div_start  datapath load pulses
//   mult_hi/lo, div_hi/lo  datapath results (divider: remainder, quotient)
//   op_ready, busy, stall  handshake and pipeline freeze
//   done, div0             one-cycle completion / divide-by-zero pulses
//   hi, lo                 architectural HI/LO registers
module muldiv_seq #(
  parameter int MULT_LAT = 32,
  parameter int DIV_LAT  = 32
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        op_valid,
  input  logic [1:0]  op_code,
  input  logic [31:0] op_a,
  input  logic [31:0] op_b,
  input  logic        cancel,
  input  logic        mf_req,
  output logic [31:0] unit_a,
  output logic [31:0] unit_b,
  output logic        mult_start,
  output logic        div_start,
  input  logic [31:0] mult_hi,
  input  logic [31:0] mult_lo,
  input  logic [31:0] div_hi,
  input  logic [31:0] div_lo,
  output logic        op_ready,
  output logic        busy,
  output logic        stall,
  output logic        done,
  output logic        div0,
  output logic [31:0] hi,
  output logic [31:0] lo
);

  typedef enum logic [1:0] {IDLE, MRUN, DRUN} state_t;

  localparam logic [1:0] OP_MULT = 2'b00;
  localparam logic [1:0] OP_DIV  = 2'b01;
  localparam logic [1:0] OP_MTHI = 2'b10;
  localparam logic [1:0] OP_MTLO = 2'b11;

  localparam logic [5:0] MULT_CNT = 6'(MULT_LAT);
  localparam logic [5:0] DIV_CNT  = 6'(DIV_LAT);

  state_t      state_q, state_d;
  logic [5:0]  cnt_q, cnt_d;
  logic [31:0] hi_q, hi_d;
  logic [31:0] lo_q, lo_d;
  logic        done_q, done_d;
  logic        div0_q, div0_d;

  logic accept;
  logic b_zero;

  assign op_ready = (state_q == IDLE);
  // A flush in the same cycle drops the request rather than launching it.
  assign accept   = op_valid & op_ready & ~cancel;
  assign b_zero   = (op_b == 32'd0);

  assign unit_a     = op_a;
  assign unit_b     = op_b;
  assign mult_start = accept & (op_code == OP_MULT);
  assign div_start  = accept & (op_code == OP_DIV) & ~b_zero;

  assign busy  = (state_q != IDLE);
  // The capture cycle is still busy, so a reader waits one more cycle and
  // then sees the freshly written HI/LO.
  assign stall = busy & (op_valid | mf_req);

  assign done = done_q;
  assign div0 = div0_q;
  assign hi   = hi_q;
  assign lo   = lo_q;

  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    hi_d    = hi_q;
    lo_d    = lo_q;
    done_d  = 1'b0;
    div0_d  = 1'b0;
    case (state_q)
      IDLE: begin
        if (accept) begin
          case (op_code)
            OP_MULT: begin
              state_d = MRUN;
              cnt_d   = MULT_CNT;
            end
            OP_DIV: begin
              if (b_zero) begin
                div0_d = 1'b1;
              end else begin
                state_d = DRUN;
                cnt_d   = DIV_CNT;
              end
            end
            OP_MTHI: hi_d = op_a;
            OP_MTLO: lo_d = op_a;
            default: ;
          endcase
        end
      end
      MRUN, DRUN: begin
        if (cancel) begin
          // Abandon the run; the datapath keeps going but is ignored.
          state_d = IDLE;
          cnt_d   = 6'd0;
        end else begin
          cnt_d = cnt_q - 6'd1;
          if (cnt_q == 6'd1) begin
            state_d = IDLE;
            done_d  = 1'b1;
            if (state_q == MRUN) begin
              hi_d = mult_hi;
              lo_d = mult_lo;
            end else begin
              hi_d = div_hi;
              lo_d = div_lo;
            end
          end
        end
      end
      default: begin
        state_d = IDLE;
        cnt_d   = 6'd0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q <= IDLE;
      cnt_q   <= 6'd0;
      hi_q    <= 32'd0;
      lo_q    <= 32'd0;
      done_q  <= 1'b0;
      div0_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
      hi_q    <= hi_d;
      lo_q    <= lo_d;
      done_q  <= done_d;
      div0_q  <= div0_d;
    end
  end

endmodule

// File: tb/tb_muldiv_seq.sv
// Directed bench for muldiv_seq with both latencies at 32. Inputs change and
// outputs are sampled 1-2 time units after each rising edge.
module tb_muldiv_seq;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        op_valid = 1'b0;
  logic [1:0]  op_code = 2'b00;
  logic [31:0] op_a = 32'd0;
  logic [31:0] op_b = 32'd0;
  logic        cancel = 1'b0;
  logic        mf_req = 1'b0;
  logic [31:0] unit_a, unit_b;
  logic        mult_start, div_start;
  logic [31:0] mult_hi = 32'd0, mult_lo = 32'd0;
  logic [31:0] div_hi = 32'd0, div_lo = 32'd0;
  logic        op_ready, busy, stall, done, div0;
  logic [31:0] hi, lo;

  int n_checks = 0;
  int n_fail   = 0;

  muldiv_seq #(.MULT_LAT(32), .DIV_LAT(32)) dut (
    .clk(clk), .reset(reset), .op_valid(op_valid), .op_code(op_code),
    .op_a(op_a), .op_b(op_b), .cancel(cancel), .mf_req(mf_req),
    .unit_a(unit_a), .unit_b(unit_b), .mult_start(mult_start),
    .div_start(div_start), .mult_hi(mult_hi), .mult_lo(mult_lo),
    .div_hi(div_hi), .div_lo(div_lo), .op_ready(op_ready), .busy(busy),
    .stall(stall), .done(done), .div0(div0), .hi(hi), .lo(lo)
  );

  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    reset = 1'b1;
    mf_req = 1'b1;
    tick;
    tick;
    #1;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %0b want 0", busy); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL reset_stall: got %0b want 0", stall); end
    n_checks++; if (op_ready !== 1'b1) begin n_fail++; $display("FAIL reset_ready: got %0b want 1", op_ready); end
    n_checks++; if (done !== 1'b0 || div0 !== 1'b0) begin n_fail++; $display("FAIL reset_pulses: done %0b div0 %0b want 0 0", done, div0); end
    n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL reset_hilo: got %h/%h want 0/0", hi, lo); end
    mf_req = 1'b0;
    reset = 1'b0;
    tick;
  endtask

  task automatic test_mult;
    int bad;
    mult_hi = 32'd0; mult_lo = 32'd42;
    op_code = 2'b00; op_a = 32'd7; op_b = 32'd6; op_valid = 1'b1;
    #1;
    n_checks++; if (mult_start !== 1'b1 || div_start !== 1'b0) begin n_fail++; $display("FAIL mult_start: got m%0b d%0b want m1 d0", mult_start, div_start); end
    n_checks++; if (unit_a !== 32'd7 || unit_b !== 32'd6) begin n_fail++; $display("FAIL mult_operands: got %0d/%0d want 7/6", unit_a, unit_b); end
    tick;
    op_valid = 1'b0;
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      if (busy !== 1'b1 || mult_start !== 1'b0 || done !== 1'b0 || lo !== 32'd0) bad++;
      tick;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL mult_busy_window: %0d bad cycles want 0", bad); end
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL mult_busy_end: got %0b want 0", busy); end
    n_checks++; if (hi !== 32'd0 || lo !== 32'd42) begin n_fail++; $display("FAIL mult_result: got %0d/%0d want 0/42", hi, lo); end
    n_checks++; if (done !== 1'b1) begin n_fail++; $display("FAIL mult_done: got %0b want 1", done); end
    tick;
    n_checks++; if (done !== 1'b0) begin n_fail++; $display("FAIL mult_done_pulse: got %0b want 0", done); end
  endtask

  task automatic test_div;
    int bad;
    div_hi = 32'd2; div_lo = 32'd14;
    op_code = 2'b01; op_a = 32'd100; op_b = 32'd7; op_valid = 1'b1;
    #1;
    n_checks++; if (div_start !== 1'b1 || mult_start !== 1'b0) begin n_fail++; $display("FAIL div_start: got d%0b m%0b want d1 m0", div_start, mult_start); end
    tick;
    op_valid = 1'b0;
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      if (busy !== 1'b1 || mult_start !== 1'b0 || div_start !== 1'b0 || hi !== 32'd0 || lo !== 32'd42) bad++;
      tick;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL div_busy_window: %0d bad cycles want 0", bad); end
    n_checks++; if (hi !== 32'd2 || lo !== 32'd14) begin n_fail++; $display("FAIL div_result: got %0d/%0d want 2/14", hi, lo); end
    n_checks++; if (done !== 1'b1 || div0 !== 1'b0 || busy !== 1'b0) begin n_fail++; $display("FAIL div_done: done %0b div0 %0b busy %0b want 1 0 0", done, div0, busy); end
  endtask

  task automatic test_div0;
    op_code = 2'b10; op_a = 32'd5; op_valid = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b0 || op_ready !== 1'b1) begin n_fail++; $display("FAIL mthi_nostall: stall %0b ready %0b want 0 1", stall, op_ready); end
    tick;
    op_code = 2'b11; op_a = 32'd9;
    tick;
    op_valid = 1'b0;
    n_checks++; if (hi !== 32'd5 || lo !== 32'd9) begin n_fail++; $display("FAIL mthi_mtlo: got %0d/%0d want 5/9", hi, lo); end
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL mtxx_quiet: busy %0b done %0b want 0 0", busy, done); end
    op_code = 2'b01; op_a = 32'd100; op_b = 32'd0; op_valid = 1'b1;
    #1;
    n_checks++; if (div_start !== 1'b0 || op_ready !== 1'b1) begin n_fail++; $display("FAIL div0_nostart: start %0b ready %0b want 0 1", div_start, op_ready); end
    tick;
    op_valid = 1'b0;
    n_checks++; if (div0 !== 1'b1) begin n_fail++; $display("FAIL div0_pulse: got %0b want 1", div0); end
    n_checks++; if (busy !== 1'b0 || op_ready !== 1'b1) begin n_fail++; $display("FAIL div0_idle: busy %0b ready %0b want 0 1", busy, op_ready); end
    n_checks++; if (hi !== 32'd5 || lo !== 32'd9) begin n_fail++; $display("FAIL div0_hilo: got %0d/%0d want 5/9", hi, lo); end
    tick;
    n_checks++; if (div0 !== 1'b0) begin n_fail++; $display("FAIL div0_pulse_end: got %0b want 0", div0); end
  endtask

  task automatic test_stall;
    int bad;
    logic want;
    mult_hi = 32'h1; mult_lo = 32'h2;
    op_code = 2'b00; op_a = 32'd3; op_b = 32'd4; op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      if (k >= 3) mf_req = 1'b1;
      #1;
      want = (k >= 3);
      if (stall !== want) bad++;
      tick;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL stall_window: %0d bad cycles want 0", bad); end
    n_checks++; if (stall !== 1'b0) begin n_fail++; $display("FAIL stall_release: got %0b want 0", stall); end
    n_checks++; if (hi !== 32'h1 || lo !== 32'h2) begin n_fail++; $display("FAIL stall_result: got %h/%h want 1/2", hi, lo); end
    mf_req = 1'b0;
  endtask

  task automatic test_cancel;
    int bad;
    mult_hi = 32'h66; mult_lo = 32'h55;
    op_code = 2'b00; op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    for (int k = 1; k <= 9; k++) tick;
    cancel = 1'b1;
    tick;
    cancel = 1'b0;
    n_checks++; if (busy !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL cancel_idle: busy %0b done %0b want 0 0", busy, done); end
    n_checks++; if (hi !== 32'h1 || lo !== 32'h2) begin n_fail++; $display("FAIL cancel_hilo: got %h/%h want 1/2", hi, lo); end
    bad = 0;
    for (int k = 0; k < 35; k++) begin
      tick;
      if (done !== 1'b0 || hi !== 32'h1 || lo !== 32'h2) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL cancel_no_capture: %0d bad cycles want 0", bad); end
    op_code = 2'b00; op_valid = 1'b1; cancel = 1'b1;
    #1;
    n_checks++; if (mult_start !== 1'b0) begin n_fail++; $display("FAIL cancel_blocks: start %0b want 0", mult_start); end
    tick;
    op_valid = 1'b0; cancel = 1'b0;
    n_checks++; if (busy !== 1'b0) begin n_fail++; $display("FAIL cancel_blocks_busy: got %0b want 0", busy); end
    op_code = 2'b10; op_a = 32'hDEADBEEF; op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    n_checks++; if (hi !== 32'hDEADBEEF || lo !== 32'h2) begin n_fail++; $display("FAIL mthi_after_cancel: got %h/%h want deadbeef/2", hi, lo); end
  endtask

  task automatic test_back_to_back;
    int bad;
    mult_hi = 32'd0; mult_lo = 32'd77;
    op_code = 2'b00; op_valid = 1'b1;
    tick;
    bad = 0;
    for (int k = 1; k <= 32; k++) begin
      if (op_ready !== 1'b0 || mult_start !== 1'b0 || stall !== 1'b1) bad++;
      tick;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL b2b_queued: %0b bad cycles want 0", bad); end
    n_checks++; if (op_ready !== 1'b1 || mult_start !== 1'b1 || stall !== 1'b0) begin n_fail++; $display("FAIL b2b_accept: ready %0b start %0b stall %0b want 1 1 0", op_ready, mult_start, stall); end
    n_checks++; if (done !== 1'b1 || lo !== 32'd77) begin n_fail++; $display("FAIL b2b_first: done %0b lo %0d want 1 77", done, lo); end
    mult_lo = 32'd88;
    tick;
    op_valid = 1'b0;
    n_checks++; if (busy !== 1'b1) begin n_fail++; $display("FAIL b2b_second_busy: got %0b want 1", busy); end
    for (int k = 1; k <= 32; k++) tick;
    n_checks++; if (done !== 1'b1 || busy !== 1'b0 || lo !== 32'd88) begin n_fail++; $display("FAIL b2b_second: done %0b busy %0b lo %0d want 1 0 88", done, busy, lo); end
  endtask

  task automatic test_reset_mid;
    int bad;
    div_hi = 32'hAAAA; div_lo = 32'hBBBB;
    op_code = 2'b01; op_a = 32'd50; op_b = 32'd3; op_valid = 1'b1;
    tick;
    op_valid = 1'b0;
    for (int k = 1; k <= 14; k++) tick;
    mf_req = 1'b1;
    #1;
    n_checks++; if (stall !== 1'b1) begin n_fail++; $display("FAIL rmid_stall_before: got %0b want 1", stall); end
    reset = 1'b1;
    #1;
    n_checks++; if (busy !== 1'b0 || stall !== 1'b0 || done !== 1'b0) begin n_fail++; $display("FAIL rmid_flags: busy %0b stall %0b done %0b want 0 0 0", busy, stall, done); end
    n_checks++; if (hi !== 32'd0 || lo !== 32'd0) begin n_fail++; $display("FAIL rmid_hilo: got %h/%h want 0/0", hi, lo); end
    tick;
    reset = 1'b0;
    mf_req = 1'b0;
    bad = 0;
    for (int k = 0; k < 40; k++) begin
      tick;
      if (done !== 1'b0 || busy !== 1'b0 || hi !== 32'd0 || lo !== 32'd0) bad++;
    end
    n_checks++; if (bad !== 0) begin n_fail++; $display("FAIL rmid_no_capture: %0d bad cycles want 0", bad); end
  endtask

  initial begin
    test_reset;
    test_mult;
    test_div;
    test_div0;
    test_stall;
    test_cancel;
    test_back_to_back;
    test_reset_mid;
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule

// File: doc/muldiv_seq.md
# muldiv_seq

Sequencer for the CPU's shared HI/LO arithmetic resources. Accepts MULT, DIV, MTHI and MTLO requests from the control unit, launches the external iterative multiplier or divider datapath with a one-cycle start pulse, counts its fixed latency and captures the result into the architectural HI/LO registers. While a run is in progress it stalls the pipeline on any new HI/LO operation or any MFHI/MFLO read.

## Interface
- MULT_LAT, 32, cycles from start edge to valid multiplier result (1..63)
- DIV_LAT, 32, cycles from start edge to valid divider result (1..63)
- clk  in  1  clock
- reset  in  1  reset, asynchronous, active-high
- op_valid  in  1  HI/LO operation request
- op_code  in  2  00 MULT, 01 DIV, 10 MTHI, 11 MTLO
- op_a  in  32  rs operand
- op_b  in  32  rt operand
- cancel  in  1  pipeline flush; aborts a run in progress
- mf_req  in  1  MFHI/MFLO in decode this cycle
- unit_a  out  32  operand A to datapaths (combinational copy of op_a)
- unit_b  out  32  operand B to datapaths (combinational copy of op_b)
- mult_start  out  1  multiplier load pulse
- div_start  out  1  divider load pulse
- mult_hi, mult_lo  in  32 each  multiplier result
- div_hi, div_lo  in  32 each  divider result (remainder, quotient)
- op_ready  out  1  request accepted this cycle if op_valid
- busy  out  1  run in progress
- stall  out  1  freeze pipeline
- done  out  1  one-cycle pulse after a result is captured
- div0  out  1  one-cycle pulse after a DIV with op_b == 0
- hi, lo  out  32 each  architectural HI/LO registers

## Operation
- States: IDLE, MRUN, DRUN. 6-bit down-counter cnt.
- Reset: state IDLE, cnt 0, hi 0, lo 0, done 0, div0 0. Reset during a run abandons it with no HI/LO update.
- op_ready = (state == IDLE). Accept = op_valid & op_ready.
- Accept MULT: mult_start = 1 (combinational). Next state MRUN, cnt = MULT_LAT.
- Accept DIV with op_b != 0: div_start = 1. Next state DRUN, cnt = DIV_LAT.
- Accept DIV with op_b == 0: no start, HI/LO unchanged, stay IDLE, div0 = 1 next cycle.
- Accept MTHI: hi <= op_a at the edge. Accept MTLO: lo <= op_a at the edge. No busy, no done.
- In MRUN or DRUN: cnt decrements each cycle. The cycle with cnt == 1 is the capture cycle. At its edge:
  - MRUN: hi <= mult_hi, lo <= mult_lo.
  - DRUN: hi <= div_hi, lo <= div_lo.
  - Then state IDLE and done = 1 for the following cycle.
- cancel in MRUN/DRUN: return to IDLE at the edge, no capture, no done. The datapath is left to run free. In IDLE, cancel blocks acceptance: a request presented with cancel = 1 is dropped.
- busy = (state != IDLE).
- stall = busy & (op_valid | mf_req).
- mult_start and div_start are never asserted together, and never outside IDLE.

## Timing
- Accept edge = E0. HI/LO take the result at edge E0+LAT. busy is high for LAT cycles. done is high in the cycle after E0+LAT.
- The datapath result must be valid in the cycle ending at E0+LAT. For MULT_LAT = 32 this matches a 32-step shift-add multiplier loaded by mult_start.
- A request or mf_req in the capture cycle stalls. It proceeds in the next cycle and reads the new HI/LO.
- Back-to-back: a second request queued behind a run is accepted in the cycle after capture. Steady-state throughput is one operation per LAT+1 cycles.
- MTHI/MTLO and div0 complete in one cycle with zero stall.
- hi and lo are registered outputs and change only at accept or capture edges.

## Test plan
- Reset, then MULT op_a = 7, op_b = 6, mult_lo = 42 at capture -> busy for 32 cycles, lo = 42, hi = 0 at E0+32, done pulse one cycle later.
- DIV op_a = 100, op_b = 7, DIV_LAT = 32 -> div_start one cycle, hi = 2, lo = 14 after 32 cycles; mult_start stays 0 throughout.
- DIV op_b = 0 with hi = 5, lo = 9 beforehand -> no div_start, div0 pulse, hi/lo stay 5/9, op_ready stays 1.
- MULT accepted, mf_req held from cycle 3 -> stall = 1 through the capture cycle, 0 the cycle after; hi/lo show the product then.
- MULT accepted, cancel in cycle 10 -> IDLE next cycle, hi/lo unchanged, no done. Then MTHI op_a = 0xDEADBEEF -> hi = 0xDEADBEEF the next cycle.
- Reset asserted mid-DRUN at cycle 15 -> busy, stall, done all 0 immediately, hi = lo = 0, and no capture after reset release.
